// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: arbitrates I/D cache block fills and D-cache write-through stores onto one pipelined memory port.
// Build option ARB_ROUND_ROBIN_EN: round-robin between simultaneous misses (default: D miss always beats I miss).
module cache_fill_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           I_miss_req,
  input  logic [15:0]                    I_miss_addr,
  input  logic                           D_miss_req,
  input  logic [15:0]                    D_miss_addr,
  input  logic                           D_wr_req,
  input  logic [15:0]                    D_wr_addr,
  input  logic [15:0]                    D_wr_data,
  input  logic                           mem_data_valid,
  input  logic [15:0]                    mem_data_in,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_data_out,
  output logic                           fill_sel,
  output logic                           fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
  output logic [15:0]                    fill_data,
  output logic                           fill_tag_we,
  output logic                           I_fill_done,
  output logic                           D_fill_done,
  output logic                           D_wr_ack
);

  localparam int CW = $clog2(BLOCK_WORDS);
  localparam logic [15:0] BASE_MASK = ~16'(2 * BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_e;

  state_e         state_q, state_d;
  logic           fill_sel_q, fill_sel_d;
  logic [15:0]    base_q, base_d;
  logic [CW:0]    issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]  ret_cnt_q, ret_cnt_d;
  logic           pick_d;
  logic           last_ret;
`ifdef ARB_ROUND_ROBIN_EN
  logic           last_d_q, last_d_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_sel_q  <= 1'b0;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fill_sel_q  <= fill_sel_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  // Miss arbitration: a lone request always wins; a tie goes to D unless D won last time (round-robin)
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = D_miss_req & (~I_miss_req | ~last_d_q);
`else
    pick_d = D_miss_req;
`endif
  end

  always_comb begin
    state_d      = state_q;
    fill_sel_d   = fill_sel_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d     = last_d_q;
`endif
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    fill_we      = 1'b0;
    fill_tag_we  = 1'b0;
    I_fill_done  = 1'b0;
    D_fill_done  = 1'b0;
    D_wr_ack     = 1'b0;
    last_ret     = (ret_cnt_q == CW'(BLOCK_WORDS - 1));

    unique case (state_q)
      IDLE: begin
        if (D_wr_req) begin
          state_d = WRITE;
        end else if (D_miss_req | I_miss_req) begin
          state_d     = FILL;
          fill_sel_d  = pick_d;
          base_d      = (pick_d ? D_miss_addr : I_miss_addr) & BASE_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d    = pick_d;
`endif
        end
      end
      WRITE: begin
        mem_en       = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = D_wr_addr;
        mem_data_out = D_wr_data;
        D_wr_ack     = 1'b1;
        state_d      = IDLE;
      end
      FILL: begin
        // Issue and return run independently; returns can overlap outstanding issues
        if (!issue_cnt_q[CW]) begin
          mem_en      = 1'b1;
          mem_addr    = base_q + 16'({issue_cnt_q, 1'b0});
          issue_cnt_d = issue_cnt_q + (CW + 1)'(1);
        end
        if (mem_data_valid) begin
          fill_we   = 1'b1;
          ret_cnt_d = ret_cnt_q + CW'(1);
          if (last_ret) begin
            fill_tag_we = 1'b1;
            I_fill_done = ~fill_sel_q;
            D_fill_done = fill_sel_q;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_sel      = fill_sel_q;
  assign fill_word_idx = ret_cnt_q;
  assign fill_data     = mem_data_in;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: directed stimulus pushes expected memory requests and fill words,
// a negedge monitor pops and compares; a latency-4 memory model answers reads with 0xA000 + word offset.
module tb_cache_fill_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        I_miss_req, D_miss_req, D_wr_req;
  logic [15:0] I_miss_addr, D_miss_addr, D_wr_addr, D_wr_data;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic        mem_en, mem_wr, fill_sel, fill_we, fill_tag_we;
  logic        I_fill_done, D_fill_done, D_wr_ack;
  logic [15:0] mem_addr, mem_data_out, fill_data;
  logic [2:0]  fill_word_idx;

  cache_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .I_miss_req(I_miss_req), .I_miss_addr(I_miss_addr),
    .D_miss_req(D_miss_req), .D_miss_addr(D_miss_addr),
    .D_wr_req(D_wr_req), .D_wr_addr(D_wr_addr), .D_wr_data(D_wr_data),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .fill_sel(fill_sel), .fill_we(fill_we), .fill_word_idx(fill_word_idx), .fill_data(fill_data),
    .fill_tag_we(fill_tag_we), .I_fill_done(I_fill_done), .D_fill_done(D_fill_done),
    .D_wr_ack(D_wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] data; } mem_exp_t;
  typedef struct { int cyc; logic sel; logic [2:0] idx; logic [15:0] data; logic last; } fill_exp_t;
  typedef struct { int due; logic [15:0] addr; } ret_t;

  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];
  ret_t      ret_q[$];
  mem_exp_t  me;
  fill_exp_t fe;
  ret_t      rr;
  int        tests = 0;
  int        fails = 0;
  int        cyc = 0;
  int        t0;
  logic      spur = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // t < 0 means cycle timing is not checked for this block
  task automatic push_fill(input logic sel, input logic [15:0] base, input int t);
    for (int k = 0; k < 8; k++)
      mem_q.push_back('{(t < 0) ? -1 : t + 1 + k, 1'b0, base + 16'(2 * k), 16'h0000});
    for (int k = 0; k < 8; k++)
      fill_q.push_back('{(t < 0) ? -1 : t + 1 + k + L, sel, 3'(k), 16'hA000 + 16'(k), (k == 7)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic side);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (side ? D_fill_done : I_fill_done) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_done side=%0d: got no done pulse in 200 cycles, expected one", side);
    end
    tick();
  endtask

  task automatic wait_ack();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (D_wr_ack) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_ack: got no D_wr_ack in 200 cycles, expected one");
    end
    tick();
  endtask

  // Memory model: fixed latency L, returns 0xA000 + word offset
  initial begin
    mem_data_valid = 1'b0;
    mem_data_in    = 16'h0000;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      mem_data_valid = 1'b0;
      mem_data_in    = 16'h0000;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        rr = ret_q.pop_front();
        mem_data_valid = 1'b1;
        mem_data_in    = 16'hA000 + 16'(rr.addr[3:1]);
      end
      if (spur) begin
        mem_data_valid = 1'b1;
        mem_data_in    = 16'h5555;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (!mem_wr) ret_q.push_back('{cyc + L, mem_addr});
        tests++;
        if (mem_q.size() == 0) begin
          fails++;
          $display("FAIL mem_req: got unexpected wr=%0b addr=%h at cyc %0d, expected no request", mem_wr, mem_addr, cyc);
        end else begin
          me = mem_q.pop_front();
          if (mem_wr !== me.wr || mem_addr !== me.addr || D_wr_ack !== me.wr ||
              (me.wr && mem_data_out !== me.data) || (me.cyc >= 0 && me.cyc != cyc)) begin
            fails++;
            $display("FAIL mem_req: got wr=%0b addr=%h data=%h ack=%0b cyc=%0d, expected wr=%0b addr=%h data=%h cyc=%0d",
                     mem_wr, mem_addr, mem_data_out, D_wr_ack, cyc, me.wr, me.addr, me.data, me.cyc);
          end
        end
      end
      if (fill_we) begin
        tests++;
        if (fill_q.size() == 0) begin
          fails++;
          $display("FAIL fill_word: got unexpected fill_we idx=%0d data=%h at cyc %0d, expected none", fill_word_idx, fill_data, cyc);
        end else begin
          fe = fill_q.pop_front();
          if (fill_sel !== fe.sel || fill_word_idx !== fe.idx || fill_data !== fe.data ||
              fill_tag_we !== fe.last || I_fill_done !== (fe.last & ~fe.sel) ||
              D_fill_done !== (fe.last & fe.sel) || (fe.cyc >= 0 && fe.cyc != cyc)) begin
            fails++;
            $display("FAIL fill_word: got sel=%0b idx=%0d data=%h tag=%0b id=%0b dd=%0b cyc=%0d, expected sel=%0b idx=%0d data=%h last=%0b cyc=%0d",
                     fill_sel, fill_word_idx, fill_data, fill_tag_we, I_fill_done, D_fill_done, cyc,
                     fe.sel, fe.idx, fe.data, fe.last, fe.cyc);
          end
        end
      end else if (fill_tag_we || I_fill_done || D_fill_done) begin
        tests++;
        fails++;
        $display("FAIL stray_pulse: got tag=%0b id=%0b dd=%0b without fill_we, expected 0", fill_tag_we, I_fill_done, D_fill_done);
      end
      if (D_wr_ack && !mem_en) begin
        tests++;
        fails++;
        $display("FAIL stray_ack: got D_wr_ack without mem_en, expected 0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by 200000, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    I_miss_req = 1'b0; I_miss_addr = '0;
    D_miss_req = 1'b0; D_miss_addr = '0;
    D_wr_req = 1'b0;   D_wr_addr = '0; D_wr_data = '0;
    #3;
    chk("reset_ctrl", 32'({mem_en, mem_wr, fill_sel, fill_we, fill_tag_we, I_fill_done, D_fill_done, D_wr_ack, fill_word_idx}), 0);
    chk("reset_addr", 32'({mem_addr, mem_data_out}), 0);
    tick(); tick();
    rst_n = 1'b1;

    // Spurious return data in IDLE
    tick();
    spur = 1'b1;
    @(negedge clk);
    chk("spur_fill_we", 32'({fill_we, mem_en}), 0);
    chk("spur_fill_data", 32'(fill_data), 32'h5555);
    tick();
    spur = 1'b0;

    // I miss at 0x1236
    I_miss_req = 1'b1; I_miss_addr = 16'h1236;
    push_fill(1'b0, 16'h1230, cyc);
    wait_done(1'b0);
    I_miss_req = 1'b0;

    // D miss at the top of memory
    tick();
    D_miss_req = 1'b1; D_miss_addr = 16'hFFF8;
    push_fill(1'b1, 16'hFFF0, cyc);
    wait_done(1'b1);
    D_miss_req = 1'b0;

    // Simultaneous I and D misses; D re-misses right after its fill
    tick();
    I_miss_req = 1'b1; I_miss_addr = 16'h2004;
    D_miss_req = 1'b1; D_miss_addr = 16'h3018;
    push_fill(1'b1, 16'h3010, cyc);
    wait_done(1'b1);
    D_miss_addr = 16'h4020;
`ifdef ARB_ROUND_ROBIN_EN
    push_fill(1'b0, 16'h2000, -1);
    push_fill(1'b1, 16'h4020, -1);
    wait_done(1'b0);
    I_miss_req = 1'b0;
    wait_done(1'b1);
    D_miss_req = 1'b0;
`else
    push_fill(1'b1, 16'h4020, -1);
    push_fill(1'b0, 16'h2000, -1);
    wait_done(1'b1);
    D_miss_req = 1'b0;
    wait_done(1'b0);
    I_miss_req = 1'b0;
`endif

    // Store raised mid-fill, with an I miss also pending
    tick();
    D_miss_req = 1'b1; D_miss_addr = 16'h0206;
    t0 = cyc;
    push_fill(1'b1, 16'h0200, t0);
    tick(); tick(); tick();
    D_wr_req = 1'b1; D_wr_addr = 16'h0040; D_wr_data = 16'hBEEF;
    I_miss_req = 1'b1; I_miss_addr = 16'h0312;
    mem_q.push_back('{t0 + 14, 1'b1, 16'h0040, 16'hBEEF});
    push_fill(1'b0, 16'h0310, t0 + 15);
    wait_done(1'b1);
    D_miss_req = 1'b0;
    wait_ack();
    D_wr_req = 1'b0;
    wait_done(1'b0);
    I_miss_req = 1'b0;

    // Reset after three returned words
    tick();
    I_miss_req = 1'b1; I_miss_addr = 16'h0506;
    t0 = cyc;
    for (int k = 0; k < 7; k++) mem_q.push_back('{t0 + 1 + k, 1'b0, 16'h0500 + 16'(2 * k), 16'h0000});
    for (int k = 0; k < 3; k++) fill_q.push_back('{t0 + 1 + k + L, 1'b0, 3'(k), 16'hA000 + 16'(k), 1'b0});
    repeat (7) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({mem_en, mem_wr, fill_sel, fill_we, fill_tag_we, I_fill_done, D_fill_done, D_wr_ack, fill_word_idx}), 0);
    chk("midrst_addr", 32'({mem_addr, mem_data_out}), 0);
    chk("midrst_fill_data", 32'(fill_data), 32'(mem_data_in));
    repeat (7) tick();
    rst_n = 1'b1;
    push_fill(1'b0, 16'h0500, cyc);
    wait_done(1'b0);
    I_miss_req = 1'b0;

    repeat (6) tick();
    chk("mem_q_empty", 32'(mem_q.size()), 0);
    chk("fill_q_empty", 32'(fill_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
